// File: rtl/sine_analyzer.sv
// ---------------------------------------------------------------------------
// sine_analyzer
//
// Measures a periodic signed sample stream (for example a DDS output).  A
// three-state hysteresis FSM tracks which half-wave the signal is in.  Each
// positive-going crossing (NEG -> POS) closes one cycle.  At that point the
// module publishes three values for the cycle just finished:
//   - the number of accepted samples in the cycle (period)
//   - the largest magnitude seen in the cycle (peak)
//   - whether the period counter saturated (period_ovf)
//
// Ports
//   clk           clock, all state updates on the rising edge
//   rst           synchronous, active-high reset
//   sample_valid  sample is accepted on a rising edge where this is high
//   sample        signed DATA_W-bit sample
//   period        samples between the last two positive-going crossings
//   peak          unsigned max |sample| over the last measured cycle
//   period_ovf    the published period value saturated
//   cycle_done    one-cycle pulse, period/peak/period_ovf were just updated
//   locked        at least one cycle has been measured since reset
//   half_sign     0 = positive half-wave (or acquiring), 1 = negative half-wave
//
// FSM states
//   state | meaning
//   ACQ   | after reset, no sample has left the hysteresis band yet
//   POS   | positive half-wave, waiting for sample <= -HYST
//   NEG   | negative half-wave, waiting for sample >= +HYST (PXing)
// ---------------------------------------------------------------------------
module sine_analyzer #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 10,
    parameter int HYST   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample,
    output logic [CNT_W-1:0]  period,
    output logic [DATA_W-1:0] peak,
    output logic              period_ovf,
    output logic              cycle_done,
    output logic              locked,
    output logic              half_sign
);

    generate
        if (HYST <= 0 || HYST >= (1 << (DATA_W - 1))) begin : g_bad_hyst
            $error("sine_analyzer: HYST must be in 1 .. 2**(DATA_W-1)-1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ACQ = 2'd0,
        POS = 2'd1,
        NEG = 2'd2
    } state_t;

    localparam logic signed [DATA_W-1:0] HYST_POS = DATA_W'(HYST);
    localparam logic signed [DATA_W-1:0] HYST_NEG = DATA_W'(-HYST);
    localparam logic [CNT_W-1:0]         CNT_ONE  = CNT_W'(1);
    localparam logic [DATA_W-1:0]        DATA_ONE = DATA_W'(1);

    state_t state;
    state_t state_nxt;

    logic signed [DATA_W-1:0] sample_s;
    logic                     above;
    logic                     below;
    logic                     pxing;
    logic [DATA_W-1:0]        mag;

    logic                     armed;
    logic [CNT_W-1:0]         cnt;
    logic                     sat;
    logic [DATA_W-1:0]        runmax;

    assign sample_s = $signed(sample);
    assign above    = (sample_s >= HYST_POS);
    assign below    = (sample_s <= HYST_NEG);

    // Positive-going crossing: only from NEG, only on an accepted sample.
    assign pxing    = sample_valid && (state == NEG) && above;

    // Two's complement negate in DATA_W bits.  The most negative value
    // wraps onto itself, which read unsigned is exactly its magnitude.
    assign mag      = sample[DATA_W-1] ? ((~sample) + DATA_ONE) : sample;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACQ;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        if (sample_valid) begin
            case (state)
                ACQ: begin
                    if (above) begin
                        state_nxt = POS;
                    end else if (below) begin
                        state_nxt = NEG;
                    end
                end
                POS: begin
                    if (below) begin
                        state_nxt = NEG;
                    end
                end
                NEG: begin
                    if (above) begin
                        state_nxt = POS;
                    end
                end
                default: begin
                    state_nxt = ACQ;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // FSM: outputs (decoded from the state register only)
    // -----------------------------------------------------------------------
    always_comb begin
        half_sign = 1'b0;
        if (state == NEG) begin
            half_sign = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Measurement datapath
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            armed      <= 1'b0;
            cnt        <= '0;
            sat        <= 1'b0;
            runmax     <= '0;
            period     <= '0;
            peak       <= '0;
            period_ovf <= 1'b0;
            cycle_done <= 1'b0;
            locked     <= 1'b0;
        end else begin
            cycle_done <= 1'b0;
            if (sample_valid) begin
                if (pxing) begin
                    // The crossing sample is the first sample of the new
                    // cycle, so the counter and running max restart with it.
                    armed  <= 1'b1;
                    cnt    <= CNT_ONE;
                    sat    <= 1'b0;
                    runmax <= mag;
                    // The first crossing after reset only arms: the cycle
                    // before it was not observed from its start.
                    if (armed) begin
                        period     <= cnt;
                        peak       <= runmax;
                        period_ovf <= sat;
                        cycle_done <= 1'b1;
                        locked     <= 1'b1;
                    end
                end else begin
                    if (armed) begin
                        if (&cnt) begin
                            sat <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    if (mag > runmax) begin
                        runmax <= mag;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sine_analyzer.sv
module tb_sine_analyzer;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 10;
    localparam int HYST   = 4;

    logic              clk;
    logic              rst;
    logic              sample_valid;
    logic [DATA_W-1:0] sample;
    logic [CNT_W-1:0]  period;
    logic [DATA_W-1:0] peak;
    logic              period_ovf;
    logic              cycle_done;
    logic              locked;
    logic              half_sign;

    sine_analyzer #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W),
        .HYST   (HYST)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample       (sample),
        .period       (period),
        .peak         (peak),
        .period_ovf   (period_ovf),
        .cycle_done   (cycle_done),
        .locked       (locked),
        .half_sign    (half_sign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int period;
        int peak;
        int ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_pulse  = 0;
    logic prev_done = 1'b0;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic expect_cycle(input int p, input int pk, input int ovf);
        exp_t e;
        e.period = p;
        e.peak   = pk;
        e.ovf    = ovf;
        exp_q.push_back(e);
    endtask

    // Monitor: compares every published measurement against the scoreboard.
    always @(negedge clk) begin
        if (cycle_done) begin
            n_pulse++;
            check("pulse_width", prev_done, 0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: got period=%0d peak=%0d ovf=%0d, expected no pulse",
                         period, peak, period_ovf);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("period", period, e.period);
                check("peak", peak, e.peak);
                check("period_ovf", period_ovf, e.ovf);
                check("locked_at_pulse", locked, 1);
            end
        end
        prev_done = cycle_done;
    end

    // One accepted sample; with gap=1 an idle cycle with a junk sample follows.
    task automatic send(input int v, input bit gap);
        sample_valid = 1'b1;
        sample       = DATA_W'(v);
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        if (gap) begin
            sample = DATA_W'(-99);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_run(input int v, input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            send(v, gap);
        end
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic idle(input int cycles);
        sample_valid = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // Four periods of +50 x10 / -50 x10, closed by one more +50 so that the
    // fourth period also ends in a crossing: crossings at samples 21/41/61/81,
    // the first of which only arms.
    task automatic square_stream(input bit gap);
        for (int c = 0; c < 4; c++) begin
            send_run(50, 10, gap);
            send_run(-50, 10, gap);
        end
        send(50, gap);
    endtask

    task automatic end_phase(input string name, input int base, input int pulses);
        idle(3);
        check({name, "_pending"}, exp_q.size(), 0);
        check({name, "_pulses"}, n_pulse - base, pulses);
    endtask

    int base;

    initial begin
        rst          = 1'b1;
        sample_valid = 1'b0;
        sample       = '0;

        // Reset state
        do_reset(2);
        idle(2);
        check("rst_period", period, 0);
        check("rst_peak", peak, 0);
        check("rst_ovf", period_ovf, 0);
        check("rst_done", cycle_done, 0);
        check("rst_locked", locked, 0);
        check("rst_half_sign", half_sign, 0);

        // Continuous square wave
        base = n_pulse;
        for (int i = 0; i < 3; i++) expect_cycle(20, 50, 0);
        square_stream(1'b0);
        end_phase("cont", base, 3);
        check("cont_locked", locked, 1);

        // Same stream with sample_valid toggling
        do_reset(1);
        check("rst2_locked", locked, 0);
        base = n_pulse;
        for (int i = 0; i < 3; i++) expect_cycle(20, 50, 0);
        square_stream(1'b1);
        end_phase("gap", base, 3);
        check("gap_locked", locked, 1);

        // -128 inside a cycle: magnitude 128
        base = n_pulse;
        expect_cycle(20, 128, 0);
        send_run(50, 9, 1'b0);
        send_run(-50, 9, 1'b0);
        send(-128, 1'b0);
        check("neg_half_sign", half_sign, 1);
        send(50, 1'b0);
        end_phase("min", base, 1);

        // Counter saturation, then recovery on the next cycle
        base = n_pulse;
        expect_cycle(1023, 50, 1);
        expect_cycle(11, 50, 0);
        send_run(-50, 1100, 1'b0);
        send(50, 1'b0);
        send_run(-50, 10, 1'b0);
        send(50, 1'b0);
        end_phase("ovf", base, 2);

        // Reset mid-cycle, with a valid sample present during reset
        send_run(50, 5, 1'b0);
        send_run(-50, 3, 1'b0);
        rst          = 1'b1;
        sample_valid = 1'b1;
        sample       = DATA_W'(-50);
        @(posedge clk);
        #1;
        rst          = 1'b0;
        sample_valid = 1'b0;
        check("mid_rst_locked", locked, 0);
        check("mid_rst_period", period, 0);
        check("mid_rst_half_sign", half_sign, 0);
        base = n_pulse;
        expect_cycle(20, 50, 0);
        send_run(-50, 10, 1'b0);
        send(50, 1'b0);
        check("rearm_locked", locked, 0);
        send_run(50, 9, 1'b0);
        send_run(-50, 10, 1'b0);
        send(50, 1'b0);
        end_phase("midrst", base, 1);

        // Hysteresis band: nothing may leave ACQ
        do_reset(1);
        base = n_pulse;
        for (int i = 0; i < 50; i++) begin
            send(3, 1'b0);
            check("hyst_half_sign_p", half_sign, 0);
            send(-3, 1'b0);
            check("hyst_half_sign_n", half_sign, 0);
        end
        end_phase("hyst", base, 0);
        check("hyst_locked", locked, 0);
        // Leaving the band with -HYST must enter NEG, proving ACQ was held.
        send(-HYST, 1'b0);
        check("hyst_exit_neg", half_sign, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sine_analyzer.md
SINE_ANALYZER -- requirements
Module: sine_analyzer

Interface
REQ-001 Parameter DATA_W, 8, sample width; samples are two's complement.
REQ-002 Parameter CNT_W, 10, width of the period counter and of the period output.
REQ-003 Parameter HYST, 4, crossing threshold magnitude; must satisfy 0 < HYST < 2**(DATA_W-1).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 sample_valid  input  1  sample is accepted on a rising edge where this is high.
REQ-007 sample  input  DATA_W  signed sample stream, e.g. a DDS generator output.
REQ-008 period  output  CNT_W  registered; accepted samples between the last two positive-going crossings.
REQ-009 peak  output  DATA_W  registered; unsigned maximum |sample| over the last measured cycle.
REQ-010 period_ovf  output  1  registered; the current period value saturated.
REQ-011 cycle_done  output  1  one-cycle pulse; period, peak and period_ovf were updated this cycle.
REQ-012 locked  output  1  registered; at least one cycle has been measured since reset.
REQ-013 half_sign  output  1  registered; 0 = positive half-wave, 1 = negative half-wave (FSM-derived).

Function
REQ-014 FSM states: ACQ, POS, NEG; the FSM advances only on accepted samples.
REQ-015 ACQ: sample >= +HYST -> POS; sample <= -HYST -> NEG; otherwise stay in ACQ. This move is not a crossing.
REQ-016 POS: sample <= -HYST -> NEG (negative-going crossing); otherwise stay in POS.
REQ-017 NEG: sample >= +HYST -> POS (positive-going crossing, "PXing"); otherwise stay in NEG.
REQ-018 Samples with magnitude < HYST never change state (hysteresis band).
REQ-019 half_sign is 1 in NEG and 0 in ACQ and POS.
REQ-020 An armed flag sets on the first PXing after reset; that first PXing produces no cycle_done.
REQ-021 Counter: on a PXing, cnt <= 1; on any other accepted sample while armed, cnt <= cnt+1, saturating at 2**CNT_W-1.
REQ-022 Saturation: when an increment is blocked at all-ones, a sticky sat flag sets; a PXing clears it.
REQ-023 Magnitude: |sample| is computed unsigned in DATA_W bits; -2**(DATA_W-1) maps to 2**(DATA_W-1) (e.g. -128 -> 128).
REQ-024 Running maximum: on a PXing, runmax <= |sample|; on any other accepted sample, runmax <= max(runmax, |sample|).
REQ-025 On a PXing with armed=1, all of the following happen in the same update, using pre-update values:
- period <= cnt
- peak <= runmax
- period_ovf <= sat
- cycle_done <= 1
- locked <= 1
REQ-026 cycle_done is asserted the clock edge after the PXing sample is accepted, for exactly one cycle; otherwise it is 0.
REQ-027 period, peak, period_ovf and locked hold their values between updates.
REQ-028 When sample_valid is low, all state, counters and outputs hold, except cycle_done, which goes 0.
REQ-029 A PXing and saturation in the same sample: the PXing wins; the counter restarts at 1.
REQ-030 There is no combinational path from inputs to outputs.

Reset
REQ-031 While rst is high at a rising edge, the following take these values:
- FSM = ACQ
- armed = 0
- cnt = 0
- sat = 0
- runmax = 0
- period = 0
- peak = 0
- period_ovf = 0
- cycle_done = 0
- locked = 0
- half_sign = 0
REQ-032 rst has priority over sample_valid; a reset mid-cycle discards the partial measurement, and the first PXing afterwards only re-arms.

Verification
REQ-033 rst high for 2 cycles, then idle -> all outputs are 0; FSM is ACQ.
REQ-034 Continuous valid; repeating +50 x10, -50 x10 for 4 periods -> cycle_done pulses 3 times; each shows period=20, peak=50, period_ovf=0; locked=1 after the first pulse.
REQ-035 Same stream as REQ-034 with sample_valid toggling every cycle -> identical period, peak and pulse count; cycle_done never lasts more than 1 cycle.
REQ-036 HYST=4; samples alternating +3, -3 for 100 accepted samples -> no cycle_done; FSM stays in ACQ; half_sign=0.
REQ-037 After lock, a cycle containing a -128 sample -> peak=128 on the next pulse.
REQ-038 Two parts:
- Overflow: after lock, hold -50 for 1100 samples, then +50 -> period=1023, period_ovf=1.
- Reset mid-cycle: assert rst inside a cycle -> the next two PXings give exactly one cycle_done.
